// File: rtl/hs_skid_slice_if.sv
// One-direction valid/ready channel. The master drives data/valid and the slave drives ready.
// A beat transfers on any rising edge where valid and ready are both high.
interface hs_skid_slice_if #(
    parameter int DATA_W = 3
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/hs_skid_slice.sv
// Two-entry registered valid/ready slice. Every output comes straight from a flop,
// so there is no combinational path from input to output and it still sustains one beat per cycle.
module hs_skid_slice #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    hs_skid_slice_if.slave   s_if,
    hs_skid_slice_if.master  m_if,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                m_valid_q, m_valid_d;
    logic                s_ready_q, s_ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                s_fire, m_fire;

    assign s_fire = s_if.valid & s_ready_q;
    assign m_fire = m_valid_q & m_if.ready;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        skid_d    = skid_q;
        m_valid_d = m_valid_q;
        s_ready_d = s_ready_q;
        cnt_d     = m_fire ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            EMPTY: begin
                // s_ready is still low on the first edge after reset, so nothing can fire here yet
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                if (s_fire) begin
                    out_d     = s_if.data;
                    m_valid_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (s_fire && m_fire) begin
                    out_d = s_if.data;
                end else if (s_fire) begin
                    skid_d    = s_if.data;
                    s_ready_d = 1'b0;
                    state_d   = FULL;
                end else if (m_fire) begin
                    m_valid_d = 1'b0;
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (m_fire) begin
                    out_d     = skid_q;
                    s_ready_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            default: begin
                state_d   = EMPTY;
                m_valid_d = 1'b0;
                s_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            cnt_q     <= cnt_d;
        end
    end

    // The state encoding doubles as the entry count
    assign occupancy  = state_q;
    assign dbg_state  = state_q;
    assign xfer_cnt   = cnt_q;
    assign s_if.ready = s_ready_q;
    assign m_if.valid = m_valid_q;
    assign m_if.data  = out_q;

endmodule

// File: tb/tb_hs_skid_slice.sv
// Self-checking bench for hs_skid_slice: a queue model of the held beats is checked every cycle,
// with directed scenarios that pin the model to literal values.
module tb_hs_skid_slice;

    localparam int DATA_W = 3;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] occupancy, occupancy_w, dbg_state, dbg_state_w;
    logic [7:0] xfer_cnt;
    logic [2:0] xfer_cnt_w;

    hs_skid_slice_if #(.DATA_W(DATA_W)) s_if ();
    hs_skid_slice_if #(.DATA_W(DATA_W)) m_if ();
    hs_skid_slice_if #(.DATA_W(DATA_W)) s_if_w ();
    hs_skid_slice_if #(.DATA_W(DATA_W)) m_if_w ();

    hs_skid_slice #(.DATA_W(DATA_W), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_if(s_if), .m_if(m_if),
        .occupancy(occupancy), .xfer_cnt(xfer_cnt), .dbg_state(dbg_state)
    );

    // Narrow-counter copy of the slice, fed the same traffic, used to exercise counter wrap
    hs_skid_slice #(.DATA_W(DATA_W), .CNT_W(3)) dut_w (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .s_if(s_if_w), .m_if(m_if_w),
        .occupancy(occupancy_w), .xfer_cnt(xfer_cnt_w), .dbg_state(dbg_state_w)
    );

    assign s_if_w.data  = s_if.data;
    assign s_if_w.valid = s_if.valid;
    assign m_if_w.ready = m_if.ready;

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    bit                exp_s_ready;
    int                exp_cnt;
    bit                mdl_s_fire;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exp_q.delete();
            exp_s_ready = 1'b0;
            exp_cnt     = 0;
            mdl_s_fire  = 1'b0;
        end else begin
            bit m_f;
            m_f        = m_if.ready && (exp_q.size() > 0);
            mdl_s_fire = s_if.valid && exp_s_ready;
            if (m_f) begin
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (mdl_s_fire) exp_q.push_back(s_if.data);
            exp_s_ready = (exp_q.size() < 2);
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            chk("m_valid", int'(m_if.valid), int'(exp_q.size() > 0));
            chk("s_ready", int'(s_if.ready), int'(exp_s_ready));
            chk("occupancy", int'(occupancy), exp_q.size());
            chk("xfer_cnt", int'(xfer_cnt), exp_cnt % 256);
            chk("xfer_cnt_w", int'(xfer_cnt_w), exp_cnt % 8);
            chk("m_valid_w", int'(m_if_w.valid), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("m_data", int'(m_if.data), int'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        s_if.valid  = 1'b0;
        s_if.data   = '0;
        m_if.ready  = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int wrap_seq[10];

    initial begin
        sys_rst_n  = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;
        #12;
        chk("rst_m_valid", int'(m_if.valid), 0);
        chk("rst_s_ready", int'(s_if.ready), 0);
        chk("rst_m_data", int'(m_if.data), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_cnt", int'(xfer_cnt), 0);
        do_reset();
        step();
        chk("first_edge_s_ready", int'(s_if.ready), 1);

        // single beat
        m_if.ready = 1'b1;
        s_if.valid = 1'b1;
        s_if.data  = 3'b101;
        step();
        s_if.valid = 1'b0;
        chk("single_m_valid", int'(m_if.valid), 1);
        chk("single_m_data", int'(m_if.data), 5);
        chk("single_occ", int'(occupancy), 1);
        step();
        chk("single_m_valid_off", int'(m_if.valid), 0);
        chk("single_cnt", int'(xfer_cnt), 1);
        chk("single_occ_off", int'(occupancy), 0);

        // streaming 0..7
        for (int i = 0; i < 8; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = 3'(i);
            step();
            chk("stream_data", int'(m_if.data), i);
            chk("stream_s_ready", int'(s_if.ready), 1);
        end
        s_if.valid = 1'b0;
        step();
        chk("stream_cnt", int'(xfer_cnt), 9);

        // backpressure: offer 1,2,3 with m_ready low
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 3'd1;
        step();
        s_if.data = 3'd2;
        step();
        chk("bp_s_ready", int'(s_if.ready), 0);
        chk("bp_occ", int'(occupancy), 2);
        s_if.data = 3'd3;
        step();
        chk("bp_hold_data", int'(m_if.data), 1);
        chk("bp_hold_occ", int'(occupancy), 2);
        m_if.ready = 1'b1;
        step();
        chk("bp_rel_data2", int'(m_if.data), 2);
        step();
        s_if.valid = 1'b0;
        chk("bp_rel_data3", int'(m_if.data), 3);
        step();
        chk("bp_drain_occ", int'(occupancy), 0);
        chk("bp_cnt", int'(xfer_cnt), 12);

        // counter wrap on the 3-bit instance: 9 transfers from reset
        do_reset();
        step();
        m_if.ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.valid = (i < 9);
            s_if.data  = 3'(i);
            step();
            wrap_seq[i] = int'(xfer_cnt_w);
        end
        s_if.valid = 1'b0;
        chk("wrap_7", wrap_seq[7], 7);
        chk("wrap_0", wrap_seq[8], 0);
        chk("wrap_1", wrap_seq[9], 1);

        // reset while FULL holding 4,5
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 3'd4;
        step();
        s_if.data = 3'd5;
        step();
        s_if.valid = 1'b0;
        chk("full_occ", int'(occupancy), 2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_m_valid", int'(m_if.valid), 0);
        chk("async_s_ready", int'(s_if.ready), 0);
        chk("async_occ", int'(occupancy), 0);
        chk("async_cnt", int'(xfer_cnt), 0);
        chk("async_cnt_w", int'(xfer_cnt_w), 0);
        @(negedge sys_clk);
        sys_rst_n  = 1'b1;
        m_if.ready = 1'b1;
        step();
        chk("post_rst_s_ready", int'(s_if.ready), 1);
        chk("post_rst_m_valid", int'(m_if.valid), 0);
        repeat (3) step();

        // random traffic; upstream holds an offered beat until it is taken
        for (int c = 0; c < 1500; c++) begin
            int bias;
            bias = (c < 500) ? 1 : ((c < 1000) ? 3 : 0);
            m_if.ready = ($urandom_range(0, 3) < bias + 1);
            if (!(s_if.valid && !mdl_s_fire)) begin
                s_if.valid = ($urandom_range(0, 3) != 0);
                s_if.data  = 3'($urandom_range(0, 7));
            end
            step();
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        repeat (4) step();
        chk("drained", int'(occupancy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_skid_slice.md
Name: hs_skid_slice

Overview:
- Two-entry, fully registered valid/ready pipeline slice.
- Inserted between the bus master's valid/data output and the slave's valid/ready input to break the combinational ready path and add one register stage.
- Zero bubbles: sustains 1 beat/cycle.
- Exposes occupancy and a completed-transfer counter for debug/verification.

Parameters:
DATA_W, 3, payload width (matches master/slave data bus)
CNT_W, 8, width of transfer counter xfer_cnt

Ports:
sys_clk  input  1  clock, all state on rising edge
sys_rst_n  input  1  asynchronous active-low reset
s_data  input  DATA_W  upstream payload (from master)
s_valid  input  1  upstream valid
s_ready  output  1  slice can accept; registered
m_data  output  DATA_W  downstream payload (to slave); registered
m_valid  output  1  downstream valid; registered
m_ready  input  1  downstream ready (from slave)
occupancy  output  2  entries held: 0, 1 or 2
xfer_cnt  output  CNT_W  count of downstream handshakes (m_valid & m_ready)

Behaviour:
- Fire definitions: s_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Storage: out_reg drives m_data; skid_reg holds one extra beat.
- s_ready, m_valid, m_data are direct flop outputs. No combinational path from any input to any output.
- Reset (sys_rst_n low, async):
  - state=EMPTY; s_ready=0; m_valid=0; m_data=0; skid_reg=0; occupancy=0; xfer_cnt=0.
  - First rising edge after deassertion sets s_ready=1. No s_fire is possible on that edge.
- States (occupancy = 0/1/2):
  - EMPTY: m_valid=0, s_ready=1.
    - s_fire -> out_reg<=s_data, m_valid<=1, go BUSY.
  - BUSY: m_valid=1, s_ready=1.
    - s_fire & m_fire -> out_reg<=s_data, stay BUSY.
    - s_fire only -> skid_reg<=s_data, s_ready<=0, go FULL.
    - m_fire only -> m_valid<=0, go EMPTY.
    - neither -> hold.
  - FULL: m_valid=1, s_ready=0.
    - m_fire -> out_reg<=skid_reg, s_ready<=1, go BUSY.
    - Otherwise hold; s_valid is ignored.
- Latency: a beat accepted at edge N is presented on m_data/m_valid after edge N (visible in cycle N+1). Minimum latency 1 cycle.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- m_data and m_valid stay stable while m_valid=1 & m_ready=0.
- s_data is sampled only on s_fire. Upstream must hold s_data/s_valid stable until s_fire; the slice does not check this.
- Throughput: with m_ready held at 1, one beat per cycle indefinitely; occupancy never exceeds 1.
- xfer_cnt:
  - Increments by 1 on each m_fire.
  - Wraps modulo 2^CNT_W with no saturation or flag.
- Simultaneous s_fire & m_fire in BUSY: occupancy stays 1 and xfer_cnt increments.
- Reset mid-operation: all held beats are discarded immediately, with outputs at reset values. Upstream must re-send.
- Unreachable state encodings recover to EMPTY.

Test Plan:
- Single beat, m_ready=1: s_data=3'b101 with s_valid one cycle -> m_valid=1 with m_data=3'b101 exactly one cycle later; then m_valid=0; xfer_cnt=1; occupancy 0->1->0.
- Streaming, m_ready=1: 8 consecutive beats 0..7 -> m_data 0..7 on 8 consecutive cycles starting 1 cycle after first; s_ready never drops; xfer_cnt=8.
- Backpressure, m_ready=0: offer 1,2,3 -> 1 and 2 accepted; s_ready=0 from the cycle after beat 2; occupancy=2; m_data holds 1. Raise m_ready -> outputs 1,2,3 in order, no gaps after release; occupancy returns to 0.
- Random m_ready/s_valid (≥1000 cycles) vs reference queue model -> identical order; no loss or duplication; occupancy in 0..2; m_data stable during stalls.
- Counter wrap, CNT_W=3: 9 transfers -> xfer_cnt sequence ends 7,0,1.
- Reset while FULL (beats 4,5 held): assert sys_rst_n=0 asynchronously -> m_valid, s_ready, occupancy, xfer_cnt read 0 without clock. After release, s_ready=1 after first edge; no stale 4/5 appears on m_data with m_valid=1.
